// File: rtl/awg_param_ctrl.sv
// awg_param_ctrl: byte-stream frame parser that loads sine-generator parameters.
// Define AWG_CHECKSUM_EN for 5-byte frames with a trailing XOR checksum byte.
module awg_param_ctrl #(
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        en,
   output logic [11:0] freq,
   output logic [2:0]  amp,
   output logic [7:0]  phase,
   output logic        upd,
   output logic        err
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
`ifdef AWG_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, CMD, DHI, DLO, CHK} state_t;
   localparam state_t LAST = CHK;
`else
   typedef enum logic [2:0] {IDLE, CMD, DHI, DLO} state_t;
   localparam state_t LAST = DLO;
`endif
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [7:0] f_cmd, f_dhi, dlo;
`ifdef AWG_CHECKSUM_EN
   logic [7:0] f_dlo;
`endif
   logic last, expire, good, chk_ok;
   always_comb begin
      last = rx_valid && state == LAST;
      expire = state != IDLE && !rx_valid && cnt == CW'(TIMEOUT_CYC - 1);
`ifdef AWG_CHECKSUM_EN
      dlo = f_dlo;
      chk_ok = rx_data == (f_cmd ^ f_dhi ^ f_dlo);
`else
      dlo = rx_data;
      chk_ok = 1'b1;
`endif
      good = chk_ok && ((f_cmd == 8'h01 && f_dhi[7:4] == 4'h0) ||
                        (f_cmd == 8'h02 && f_dhi == 8'h00 && dlo != 8'h00 && dlo <= 8'd7) ||
                        (f_cmd == 8'h03 && f_dhi == 8'h00) ||
                        (f_cmd == 8'h04 && f_dhi == 8'h00 && dlo[7:1] == 7'h00));
      state_nx = expire ? IDLE :
                 !rx_valid ? state :
                 state == IDLE ? (rx_data == 8'hA5 ? CMD : IDLE) :
                 state == LAST ? IDLE : state_t'(state + 3'd1);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
      end else begin
         state <= state_nx;
         cnt <= (state_nx == IDLE || rx_valid) ? '0 : cnt + CW'(1);
      end
   end
   // Frame fields are latched as they arrive; validation happens only on the last byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_cmd <= '0;
         f_dhi <= '0;
`ifdef AWG_CHECKSUM_EN
         f_dlo <= '0;
`endif
         en <= 1'b0;
         freq <= '0;
         amp <= 3'd1;
         phase <= '0;
         upd <= 1'b0;
         err <= 1'b0;
      end else begin
         if (rx_valid && state == CMD) f_cmd <= rx_data;
         if (rx_valid && state == DHI) f_dhi <= rx_data;
`ifdef AWG_CHECKSUM_EN
         if (rx_valid && state == DLO) f_dlo <= rx_data;
`endif
         upd <= last && good;
         err <= (last && !good) || expire;
         if (last && good) begin
            if (f_cmd == 8'h01) freq <= {f_dhi[3:0], dlo};
            if (f_cmd == 8'h02) amp <= dlo[2:0];
            if (f_cmd == 8'h03) phase <= dlo;
            if (f_cmd == 8'h04) en <= dlo[0];
         end
      end
   end
endmodule
